// File: rtl/seq_detector_param_pkg.sv
// Shared constants for the parametrised serial sequence detector: length limits,
// mode encodings, default pattern, and a fill-counter width helper.
package seq_detector_param_pkg;

  localparam int         SEQDET_MAX_LEN     = 32;
  localparam logic       SEQDET_MODE_NOVL   = 1'b0;
  localparam logic       SEQDET_MODE_OVL    = 1'b1;
  localparam int         SEQDET_DEF_LEN     = 4;
  localparam logic [3:0] SEQDET_DEF_PATTERN = 4'b1011;
  localparam int         SEQDET_DEF_CNT_W   = 8;

  // fill must be able to hold the value len itself
  function automatic int seqdet_fill_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_window.sv
// History shift register plus saturating fill counter for the sequence detector.
// clear zeroes only the fill count; the window contents are kept.
module seq_det_window
  import seq_detector_param_pkg::*;
#(
  parameter int PAT_LEN = SEQDET_DEF_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               bit_in,
  output logic [PAT_LEN-1:0] win,
  output logic               full_m1
);

  localparam int            FW       = seqdet_fill_w(PAT_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);
  localparam logic [FW-1:0] FILL_THR = FW'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] win_q, win_d;
  logic [FW-1:0]      fill_q, fill_d;

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (shift_en) begin
      win_d = {win_q[PAT_LEN-2:0], bit_in};
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
    // a non-overlap hit shifts and clears in the same cycle
    if (clear) fill_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

  assign win     = win_q;
  assign full_m1 = (fill_q >= FILL_THR);

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with runtime pattern and overlap mode.
// Optional saturating match counter enabled by SEQDET_MATCH_COUNT_EN.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int                 PAT_LEN = SEQDET_DEF_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = SEQDET_DEF_PATTERN,
  parameter int                 CNT_W   = SEQDET_DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PI,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               PO
`ifdef SEQDET_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  if (PAT_LEN < 2 || PAT_LEN > SEQDET_MAX_LEN) begin : g_bad_len
    $error("seq_detector_param: PAT_LEN out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be at least 1");
  end

  logic [PAT_LEN-1:0] pat_q;
  logic               po_q;
  logic [PAT_LEN-1:0] win;
  logic [PAT_LEN-1:0] nxt;
  logic               full_m1;
  logic               hit;
  logic               shift_en;
  logic               clear;

  assign nxt      = {win[PAT_LEN-2:0], PI};
  assign hit      = full_m1 && (nxt == pat_q);
  // pat_load wins over in_valid, so the bit presented with a load is dropped
  assign shift_en = in_valid && !pat_load;
  assign clear    = pat_load || (shift_en && hit && (overlap == SEQDET_MODE_NOVL));

  seq_det_window #(
    .PAT_LEN (PAT_LEN)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clear    (clear),
    .bit_in   (PI),
    .win      (win),
    .full_m1  (full_m1)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q <= PATTERN;
      po_q  <= 1'b0;
    end else if (pat_load) begin
      pat_q <= pat_in;
      po_q  <= 1'b0;
    end else if (in_valid) begin
      po_q  <= hit;
    end else begin
      po_q  <= 1'b0;
    end
  end

  assign PO = po_q;

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (pat_load) begin
      cnt_q <= '0;
    end else if (in_valid && hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule
